// File: rtl/eth_tx_frame_arbiter.sv
// eth_tx_frame_arbiter: frame-granular round-robin arbiter in front of the MAC tx AXI-stream port,
// with abort of stalled frames (closed with tuser=1) followed by draining of the frame remainder.
module eth_tx_frame_arbiter #(
  parameter int PORTS = 4,
  parameter int TIMEOUT = 1024,
  localparam int IW = $clog2(PORTS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PORTS*8-1:0] s_axis_tdata,
  input  logic [PORTS-1:0]   s_axis_tvalid,
  output logic [PORTS-1:0]   s_axis_tready,
  input  logic [PORTS-1:0]   s_axis_tlast,
  input  logic [PORTS-1:0]   s_axis_tuser,
  output logic [7:0]         m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic               m_axis_tlast,
  output logic               m_axis_tuser,
  input  logic [PORTS-1:0]   port_enable,
  output logic               grant_valid,
  output logic [IW-1:0]      grant_index,
  output logic               abort_pulse
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, XFER, ABORT, DRAIN} state_t;
  state_t state;
  logic [IW-1:0] last, pick, idx;
  logic [CW-1:0] cnt;
  logic [PORTS-1:0] req;
  logic found, g_valid, g_last, xfer, abrt, fire;
  // rotating priority: search last+1 .. last+PORTS, so the previous winner comes last
  always_comb begin
    req = s_axis_tvalid & port_enable;
    pick = '0;
    idx = '0;
    found = 1'b0;
    for (int k = 1; k <= PORTS; k++) begin
      idx = IW'((int'(last) + k) % PORTS);
      if (!found && req[idx]) begin
        pick = idx;
        found = 1'b1;
      end
    end
  end
  assign g_valid = s_axis_tvalid[grant_index];
  assign g_last = s_axis_tlast[grant_index];
  assign xfer = state == XFER;
  assign abrt = state == ABORT;
  assign fire = xfer && !g_valid && cnt == CW'(TIMEOUT - 1);
  assign grant_valid = state != IDLE;
  assign m_axis_tdata = xfer ? s_axis_tdata[{grant_index, 3'b000} +: 8] : 8'h00;
  assign m_axis_tvalid = xfer ? g_valid : abrt;
  assign m_axis_tlast = xfer ? g_last : abrt;
  assign m_axis_tuser = xfer ? s_axis_tuser[grant_index] : abrt;
  assign s_axis_tready = xfer ? (PORTS'(m_axis_tready) << grant_index)
                       : state == DRAIN ? (PORTS'(1) << grant_index) : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last <= IW'(PORTS - 1);
      grant_index <= '0;
      cnt <= '0;
      abort_pulse <= 1'b0;
    end else begin
      abort_pulse <= fire;
      case (state)
        IDLE: if (found) begin
          grant_index <= pick;
          cnt <= '0;
          state <= XFER;
        end
        XFER: if (g_valid) begin
          cnt <= '0;
          if (m_axis_tready && g_last) begin
            last <= grant_index;
            state <= IDLE;
          end
        end else if (fire) state <= ABORT;
        else cnt <= cnt + 1'b1;
        ABORT: if (m_axis_tready) state <= DRAIN;
        DRAIN: if (g_valid && g_last) begin
          last <= grant_index;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// tb_eth_tx_frame_arbiter: directed scenario tests for the frame arbiter (PORTS=4, TIMEOUT=16).
// Source ports emit byte p*64+i at position i; every MAC-side beat is logged and checked.
module tb_eth_tx_frame_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  logic [31:0] s_tdata;
  logic [3:0] s_tvalid, s_tready, s_tlast, s_tuser, port_enable;
  logic [7:0] m_tdata;
  logic m_tvalid, mrdy, m_tlast, m_tuser, grant_valid, abort_pulse;
  logic [1:0] grant_index;
  int tests = 0, fails = 0, cyc = 0, aborts = 0;
  int len[4], pos[4], stall_at[4], stall_left[4];
  bit act[4];
  logic [7:0] bq_data[$];
  bit bq_last[$], bq_user[$];
  int bq_cyc[$], bq_gi[$];

  eth_tx_frame_arbiter #(.PORTS(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(mrdy),
    .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
    .port_enable(port_enable), .grant_valid(grant_valid),
    .grant_index(grant_index), .abort_pulse(abort_pulse)
  );

  always #5 clk = ~clk;

  task automatic drive();
    for (int p = 0; p < 4; p++) begin
      s_tvalid[p] = act[p] && pos[p] < len[p] && !(pos[p] == stall_at[p] && stall_left[p] > 0);
      s_tdata[p*8 +: 8] = 8'(p * 64 + pos[p]);
      s_tlast[p] = pos[p] == len[p] - 1;
      s_tuser[p] = 1'b0;
    end
  endtask

  task automatic start(input int p, input int n, input int sa, input int sl);
    act[p] = 1'b1;
    pos[p] = 0;
    len[p] = n;
    stall_at[p] = sa;
    stall_left[p] = sl;
    drive();
  endtask

  task automatic clear_mon();
    bq_data.delete(); bq_last.delete(); bq_user.delete(); bq_cyc.delete(); bq_gi.delete();
    aborts = 0;
  endtask

  task automatic step();
    logic [3:0] hs;
    @(negedge clk);
    hs = s_tvalid & s_tready;
    if (m_tvalid && mrdy) begin
      bq_data.push_back(m_tdata); bq_last.push_back(m_tlast); bq_user.push_back(m_tuser);
      bq_cyc.push_back(cyc); bq_gi.push_back(int'(grant_index));
    end
    if (abort_pulse) aborts++;
    @(posedge clk);
    #1;
    cyc++;
    for (int p = 0; p < 4; p++)
      if (hs[p]) pos[p]++;
      else if (act[p] && pos[p] == stall_at[p] && stall_left[p] > 0) stall_left[p]--;
    drive();
  endtask

  task automatic run_done(input int budget, input string name);
    bit done;
    for (int n = 0; ; n++) begin
      done = grant_valid == 1'b0;
      for (int p = 0; p < 4; p++) if (act[p] && pos[p] < len[p]) done = 1'b0;
      if (done) return;
      if (n >= budget) begin
        tests++; fails++;
        $display("FAIL %s_timeout: not finished after %0d cycles", name, budget);
        return;
      end
      step();
    end
  endtask

  task automatic run_until(input int p, input int target, input int budget, input string name);
    for (int n = 0; pos[p] < target; n++) begin
      if (n >= budget) begin
        tests++; fails++;
        $display("FAIL %s_wait: port %0d at byte %0d, wanted %0d", name, p, pos[p], target);
        return;
      end
      step();
    end
  endtask

  task automatic test_reset();
    start(1, 1, -1, 0);
    start(2, 1, -1, 0);
    repeat (3) @(posedge clk);
    #1;
    tests += 5;
    if (grant_valid !== 1'b0) begin fails++; $display("FAIL rst_grant_valid: got %b want 0", grant_valid); end
    if (grant_index !== 2'd0) begin fails++; $display("FAIL rst_grant_index: got %0d want 0", grant_index); end
    if (abort_pulse !== 1'b0) begin fails++; $display("FAIL rst_abort_pulse: got %b want 0", abort_pulse); end
    if (s_tready !== 4'h0) begin fails++; $display("FAIL rst_s_tready: got %b want 0000", s_tready); end
    if (m_tvalid !== 1'b0) begin fails++; $display("FAIL rst_m_tvalid: got %b want 0", m_tvalid); end
    act[1] = 1'b0; act[2] = 1'b0;
    drive();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int errs = 0;
    clear_mon();
    for (int p = 0; p < 4; p++) start(p, 64, -1, 0);
    run_done(400, "b2b");
    tests++;
    if (bq_data.size() != 256) begin fails++; $display("FAIL b2b_count: got %0d beats want 256", bq_data.size()); end
    for (int i = 0; i < bq_data.size(); i++)
      if (bq_data[i] !== 8'(i) || bq_last[i] !== (i % 64 == 63) || bq_user[i] !== 1'b0 || bq_gi[i] != i / 64)
        errs++;
    tests++;
    if (errs != 0) begin fails++; $display("FAIL b2b_data: %0d bad beats want 0", errs); end
    for (int f = 1; f < 4; f++)
      if (bq_cyc.size() > 64 * f) begin
        tests++;
        if (bq_cyc[64*f] - bq_cyc[64*f-1] != 2) begin
          fails++; $display("FAIL b2b_gap%0d: got %0d cycles want 2", f, bq_cyc[64*f] - bq_cyc[64*f-1]);
        end
      end
  endtask

  task automatic test_rotation();
    start(2, 4, -1, 0);
    run_done(40, "rot_p2");
    clear_mon();
    start(0, 4, -1, 0);
    start(3, 4, -1, 0);
    run_done(40, "rot");
    tests++;
    if (bq_data.size() != 8) begin fails++; $display("FAIL rot_count: got %0d beats want 8", bq_data.size()); end
    if (bq_data.size() == 8) begin
      tests += 2;
      if (bq_gi[0] != 3 || bq_data[0] !== 8'd192) begin
        fails++; $display("FAIL rot_first: got port %0d data %0d want port 3 data 192", bq_gi[0], bq_data[0]);
      end
      if (bq_gi[4] != 0 || bq_data[4] !== 8'd0) begin
        fails++; $display("FAIL rot_second: got port %0d data %0d want port 0 data 0", bq_gi[4], bq_data[4]);
      end
    end
  endtask

  task automatic test_abort();
    clear_mon();
    start(1, 20, 10, 16);
    run_done(200, "abort");
    tests += 3;
    if (aborts != 1) begin fails++; $display("FAIL abort_pulse_count: got %0d want 1", aborts); end
    if (bq_data.size() != 11) begin fails++; $display("FAIL abort_beats: got %0d want 11", bq_data.size()); end
    if (pos[1] != 20) begin fails++; $display("FAIL abort_drain: port 1 consumed %0d want 20", pos[1]); end
    if (bq_data.size() == 11) begin
      tests += 2;
      if (bq_data[10] !== 8'h00 || bq_last[10] !== 1'b1 || bq_user[10] !== 1'b1) begin
        fails++; $display("FAIL abort_beat: got data %0d last %b user %b want 0 1 1", bq_data[10], bq_last[10], bq_user[10]);
      end
      if (bq_data[9] !== 8'd73 || bq_last[9] !== 1'b0) begin
        fails++; $display("FAIL abort_tenth: got data %0d last %b want 73 0", bq_data[9], bq_last[9]);
      end
    end
    clear_mon();
    start(1, 20, 10, 15);
    run_done(200, "stall15");
    tests += 2;
    if (aborts != 0) begin fails++; $display("FAIL stall15_abort: got %0d aborts want 0", aborts); end
    if (bq_data.size() != 20) begin fails++; $display("FAIL stall15_beats: got %0d want 20", bq_data.size()); end
    if (bq_data.size() == 20) begin
      tests++;
      if (bq_data[19] !== 8'd83 || bq_last[19] !== 1'b1 || bq_user[19] !== 1'b0) begin
        fails++; $display("FAIL stall15_end: got data %0d last %b user %b want 83 1 0", bq_data[19], bq_last[19], bq_user[19]);
      end
    end
  endtask

  task automatic test_backpressure();
    int errs = 0;
    clear_mon();
    start(2, 30, -1, 0);
    run_until(2, 10, 40, "bp");
    mrdy = 1'b0;
    repeat (100) step();
    tests += 2;
    if (grant_valid !== 1'b1) begin fails++; $display("FAIL bp_hold_grant: got %b want 1", grant_valid); end
    if (s_tready !== 4'h0) begin fails++; $display("FAIL bp_tready: got %b want 0000", s_tready); end
    mrdy = 1'b1;
    run_done(100, "bp");
    tests += 2;
    if (aborts != 0) begin fails++; $display("FAIL bp_abort: got %0d aborts want 0", aborts); end
    if (bq_data.size() != 30) begin fails++; $display("FAIL bp_beats: got %0d want 30", bq_data.size()); end
    for (int i = 0; i < bq_data.size(); i++)
      if (bq_data[i] !== 8'(128 + i) || bq_last[i] !== (i == 29) || bq_user[i] !== 1'b0) errs++;
    tests++;
    if (errs != 0) begin fails++; $display("FAIL bp_data: %0d bad beats want 0", errs); end
  endtask

  task automatic test_enable();
    clear_mon();
    port_enable = 4'b1110;
    start(0, 5, -1, 0);
    start(1, 5, -1, 0);
    run_until(1, 2, 20, "en");
    port_enable = 4'b1100;
    run_until(1, 5, 20, "en");
    repeat (20) step();
    tests += 3;
    if (bq_data.size() != 5) begin fails++; $display("FAIL en_beats: got %0d want 5", bq_data.size()); end
    if (pos[0] != 0) begin fails++; $display("FAIL en_port0: port 0 consumed %0d want 0", pos[0]); end
    if (grant_valid !== 1'b0) begin fails++; $display("FAIL en_idle: grant_valid %b want 0", grant_valid); end
    if (bq_data.size() == 5) begin
      tests++;
      if (bq_gi[0] != 1 || bq_data[4] !== 8'd68 || bq_last[4] !== 1'b1) begin
        fails++; $display("FAIL en_frame: got port %0d end %0d last %b want 1 68 1", bq_gi[0], bq_data[4], bq_last[4]);
      end
    end
    act[0] = 1'b0;
    port_enable = 4'hF;
    drive();
  endtask

  task automatic test_reset_mid();
    clear_mon();
    start(3, 20, -1, 0);
    run_until(3, 5, 20, "rstm");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests += 4;
    if (grant_valid !== 1'b0) begin fails++; $display("FAIL rstm_grant_valid: got %b want 0", grant_valid); end
    if (grant_index !== 2'd0) begin fails++; $display("FAIL rstm_grant_index: got %0d want 0", grant_index); end
    if (m_tvalid !== 1'b0) begin fails++; $display("FAIL rstm_m_tvalid: got %b want 0", m_tvalid); end
    if (s_tready !== 4'h0) begin fails++; $display("FAIL rstm_s_tready: got %b want 0000", s_tready); end
    @(posedge clk);
    #1;
    clear_mon();
    start(0, 4, -1, 0);
    start(3, 4, -1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_done(40, "rstm");
    tests++;
    if (bq_data.size() != 8) begin fails++; $display("FAIL rstm_beats: got %0d want 8", bq_data.size()); end
    if (bq_data.size() == 8) begin
      tests++;
      if (bq_gi[0] != 0 || bq_data[0] !== 8'd0 || bq_gi[4] != 3) begin
        fails++; $display("FAIL rstm_priority: got ports %0d,%0d want 0,3", bq_gi[0], bq_gi[4]);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    mrdy = 1'b1;
    port_enable = 4'hF;
    for (int p = 0; p < 4; p++) begin
      act[p] = 1'b0; len[p] = 0; pos[p] = 0; stall_at[p] = -1; stall_left[p] = 0;
    end
    drive();
    test_reset();
    test_back_to_back();
    test_rotation();
    test_abort();
    test_backpressure();
    test_enable();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
